// File: rtl/id_ex_skid.sv
// Decode-to-execute pipeline register with a one-entry skid buffer.
// id_ready is registered so no ex_ready-to-id_ready timing path exists.
module id_ex_skid #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NSRC     = 2,
   parameter int unsigned RADDR_W  = 5,
   parameter int unsigned ALUOP_W  = 7,
   parameter int unsigned FUNCT3_W = 3,
   parameter logic [ALUOP_W-1:0] NOP_OP = 7'b0010011
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     id_valid,
   output logic                     id_ready,
   input  logic [ALUOP_W-1:0]       id_aluop,
   input  logic [FUNCT3_W-1:0]      id_funct3,
   input  logic [NSRC*XLEN-1:0]     id_ops,
   input  logic [RADDR_W-1:0]       id_wreg,
   input  logic                     id_wd,
   output logic                     ex_valid,
   input  logic                     ex_ready,
   output logic [ALUOP_W-1:0]       ex_aluop,
   output logic [FUNCT3_W-1:0]      ex_funct3,
   output logic [NSRC*XLEN-1:0]     ex_ops,
   output logic [RADDR_W-1:0]       ex_wreg,
   output logic                     ex_wd,
   output logic [31:0]              bubble_cnt
);

   typedef struct packed {
      logic [ALUOP_W-1:0]   aluop;
      logic [FUNCT3_W-1:0]  funct3;
      logic [NSRC*XLEN-1:0] ops;
      logic [RADDR_W-1:0]   wreg;
      logic                 wd;
   } entry_t;

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   state_e      state_q, state_d;
   entry_t      main_q, main_d, skid_q, skid_d, id_ent;
   logic        id_ready_q;
   logic [31:0] bubble_q;
   logic        accept, consume;

   assign id_ent   = '{aluop: id_aluop, funct3: id_funct3, ops: id_ops, wreg: id_wreg, wd: id_wd};
   assign ex_valid = (state_q != StEmpty);
   assign id_ready = id_ready_q;
   assign accept   = id_valid & id_ready_q;
   assign consume  = ex_valid & ex_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         StEmpty: begin
            if (accept) begin
               state_d = StOne;
               main_d  = id_ent;
            end
         end
         StOne: begin
            if (accept && consume) begin
               main_d = id_ent;
            end else if (accept) begin
               state_d = StTwo;
               skid_d  = id_ent;
            end else if (consume) begin
               state_d = StEmpty;
            end
         end
         StTwo: begin
            if (consume) begin
               state_d = StOne;
               main_d  = skid_q;
            end
         end
         default: state_d = StEmpty;
      endcase
      // Redirect discards everything, including this edge's handshakes.
      if (flush) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StEmpty;
         id_ready_q <= 1'b1;
         bubble_q   <= '0;
      end else begin
         state_q    <= state_d;
         id_ready_q <= (state_d != StTwo);
         if (ex_ready && !ex_valid && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_q <= bubble_q + 32'd1;
         end
      end
   end

   // Payload needs no reset: the bubble mux hides it while the stage is empty.
   always_ff @(posedge clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
   end

   always_comb begin
      ex_aluop  = NOP_OP;
      ex_funct3 = '0;
      ex_ops    = '0;
      ex_wreg   = '0;
      ex_wd     = 1'b0;
      if (ex_valid) begin
         ex_aluop  = main_q.aluop;
         ex_funct3 = main_q.funct3;
         ex_ops    = main_q.ops;
         ex_wreg   = main_q.wreg;
         ex_wd     = main_q.wd;
      end
   end

   assign bubble_cnt = bubble_q;

endmodule

// File: doc/id_ex_skid.md
ID_EX_SKID -- requirements
Module: id_ex_skid

Interface
REQ-001 Parameter XLEN, default 32, operand width in bits.
REQ-002 Parameter NSRC, default 2, number of operand channels (1..4).
REQ-003 Parameter RADDR_W, default 5, destination register address width.
REQ-004 Parameter ALUOP_W, default 7, ALU opcode width.
REQ-005 Parameter FUNCT3_W, default 3, ALU sub-function width.
REQ-006 Parameter NOP_OP, default 7'b0010011, opcode driven on bubble cycles.
REQ-007 Ports SHALL be as follows; reset rst, synchronous, active-high; clock clk:
 clk  in  1  clock, all state on rising edge
 rst  in  1  synchronous active-high reset
 flush  in  1  kill all held entries (branch redirect)
 id_valid  in  1  decode presents an instruction
 id_ready  out  1  stage can accept this cycle
 id_aluop  in  ALUOP_W  ALU opcode
 id_funct3  in  FUNCT3_W  ALU sub-function
 id_ops  in  NSRC*XLEN  operands, channel k at bits [k*XLEN +: XLEN]
 id_wreg  in  RADDR_W  destination register
 id_wd  in  1  write-back enable
 ex_valid  out  1  execute holds a valid instruction
 ex_ready  in  1  execute consumes this cycle
 ex_aluop, ex_funct3, ex_ops, ex_wreg, ex_wd  out  as id_*  execute-side fields
 bubble_cnt  out  32  saturating count of starved cycles

Function
REQ-008 Storage SHALL be two entries: MAIN (drives ex_*) and SKID; states EMPTY (none valid), ONE (MAIN valid), TWO (both valid).
REQ-009 id_ready SHALL be a register output, 1 in EMPTY and ONE, 0 in TWO; no combinational path from ex_ready to id_ready.
REQ-010 Accept = id_valid & id_ready; consume = ex_valid & ex_ready.
REQ-011 EMPTY: accept -> ONE, MAIN loaded; else stay.
REQ-012 ONE: accept & consume -> ONE, MAIN reloaded; accept only -> TWO, SKID loaded; consume only -> EMPTY; neither -> stay.
REQ-013 TWO: consume -> ONE, MAIN loaded from SKID; else stay, both held unchanged.
REQ-014 Latency: instruction accepted at edge N SHALL appear on ex_* with ex_valid=1 after edge N (cycle N+1) when stage was EMPTY or MAIN consumed at edge N.
REQ-015 Instruction order SHALL be preserved; no entry dropped or duplicated without flush.
REQ-016 ex_valid=1 when state is ONE or TWO; 0 in EMPTY.
REQ-017 When ex_valid=0, ex_* SHALL show bubble: ex_aluop=NOP_OP, ex_funct3=0, ex_ops=0, ex_wreg=0, ex_wd=0.
REQ-018 ex_* fields SHALL hold stable while ex_valid=1 and ex_ready=0.
REQ-019 flush=1 at edge N SHALL force EMPTY after edge N, id_ready=1; any accept or consume at edge N is discarded; flush has priority over all transitions.
REQ-020 bubble_cnt SHALL increment at each edge where ex_ready=1, ex_valid=0, rst=0; saturates at 32'hFFFF_FFFF; unaffected by flush.
REQ-021 Field widths SHALL follow parameters exactly; no truncation or sign extension of operands.

Reset
REQ-022 rst=1 at an edge SHALL force EMPTY, id_ready=1, ex_valid=0, bubble ex_* values per REQ-017, bubble_cnt=0.
REQ-023 rst SHALL take priority over flush and all handshakes; entries held mid-stall are discarded.
REQ-024 First cycle after rst deasserts, an accept SHALL be honoured.

Verification
REQ-025 Streaming: id_valid=1, ex_ready=1 every cycle, ops 1,2,3... -> ex_ops 1,2,3... one cycle later, one per cycle, id_ready constantly 1.
REQ-026 Back-pressure: ex_ready=0 with A in MAIN, present B -> TWO, id_ready=0, ex shows A stable; ex_ready=1 -> A consumed, then B, id_ready returns 1 the following cycle.
REQ-027 Flush in TWO with id_valid=1 -> next cycle ex_valid=0, ex_aluop=NOP_OP, ex_wd=0, id_ready=1; neither held entry nor presented entry ever appears.
REQ-028 Bubble counter: rst, then 5 cycles ex_ready=1, id_valid=0 -> bubble_cnt=5; preload near saturation (force) -> holds 32'hFFFF_FFFF.
REQ-029 Reset mid-stall: TWO state, assert rst one cycle -> EMPTY, ex_valid=0, bubble_cnt=0, id_ready=1.
REQ-030 Parameter sweep: NSRC=3, XLEN=64 -> channel 2 operand 64'hDEAD_BEEF_0123_4567 reaches ex_ops[191:128] unchanged.
